sha256_nonce_sequencer: RTL and testbench

// Job sequencer that sits directly upstream of sha256_transform and also consumes its tx_hash.
// - Loads a job: midstate, 96-bit header tail, nonce range.
// - Each LOOP-cycle slot, drives cnt/feedback and rx_state/rx_input (tail + nonce + padding), advancing the nonce.
// - Checks each returned hash against a leading-zero target and reports hits through a valid/ready port.

---
 rtl/sha256_nonce_sequencer.sv | 142 ++++++++++++++
 tb/tb_sha256_nonce_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_nonce_sequencer.sv
// Nonce job sequencer for a LOOP-folded sha256_transform: feeds one message block per slot,
// tracks which nonce each returned hash belongs to, and holds leading-zero hits for a consumer.
module sha256_nonce_sequencer #(
   parameter int unsigned LOOP      = 4,
   parameter int unsigned ZERO_BITS = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [255:0] midstate,
   input  logic [95:0]  data_tail,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_end,
   output logic         busy,
   output logic         done,
   output logic         feedback,
   output logic [5:0]   cnt,
   output logic [255:0] rx_state,
   output logic [511:0] rx_input,
   input  logic [255:0] tx_hash,
   output logic         golden_valid,
   input  logic         golden_ready,
   output logic [31:0]  golden_nonce,
   output logic         golden_overflow
);

   // Issue edge E to compare edge E+65: 65 stages of {valid, nonce}.
   localparam int unsigned Depth  = 65;
   localparam logic [5:0]  CntMax = 6'(LOOP - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e         state_q, state_d;
   logic [5:0]     cnt_q;
   logic [6:0]     drain_q;
   logic [31:0]    nonce_q, end_q;
   logic [95:0]    tail_q;
   logic [255:0]   mid_q;
   logic [Depth-1:0] pipe_vld_q;
   logic [31:0]    pipe_nonce_q [Depth];
   logic           gv_q, ovf_q, done_q;
   logic [31:0]    gn_q;
   logic           accept, issue, drain_last, hit, pop;
   logic           unused_hash;

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      issue      = 1'b0;
      drain_last = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               accept  = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            if (cnt_q == 6'd0) begin
               issue = 1'b1;
               if (nonce_q == end_q) state_d = StDrain;
            end
         end
         StDrain: begin
            if (drain_q == 7'd64) begin
               drain_last = 1'b1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   assign hit = pipe_vld_q[Depth-1] && (tx_hash[255 -: ZERO_BITS] == '0);
   assign pop = gv_q && golden_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         drain_q    <= '0;
         nonce_q    <= '0;
         end_q      <= '0;
         tail_q     <= '0;
         mid_q      <= '0;
         pipe_vld_q <= '0;
         for (int i = 0; i < Depth; i++) pipe_nonce_q[i] <= '0;
         gv_q       <= 1'b0;
         gn_q       <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         if (accept) begin
            mid_q   <= midstate;
            tail_q  <= data_tail;
            nonce_q <= nonce_start;
            end_q   <= nonce_end;
         end else if (issue) begin
            nonce_q <= nonce_q + 32'd1;
         end

         if (state_q == StIdle || drain_last) cnt_q <= '0;
         else                                 cnt_q <= (cnt_q == CntMax) ? 6'd0 : cnt_q + 6'd1;

         drain_q <= (state_q == StDrain) ? drain_q + 7'd1 : 7'd0;
         done_q  <= drain_last;

         pipe_vld_q <= {pipe_vld_q[Depth-2:0], issue};
         for (int i = Depth - 1; i > 0; i--) pipe_nonce_q[i] <= pipe_nonce_q[i-1];
         pipe_nonce_q[0] <= nonce_q;

         // A hit replaces a popped entry on the same edge; otherwise a full register drops it.
         if (accept) ovf_q <= 1'b0;
         if (hit) begin
            if (!gv_q || pop) begin
               gv_q <= 1'b1;
               gn_q <= pipe_nonce_q[Depth-1];
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (pop) begin
            gv_q <= 1'b0;
         end
      end
   end

   assign busy            = (state_q != StIdle);
   assign done            = done_q;
   assign cnt             = cnt_q;
   assign feedback        = (cnt_q != 6'd0);
   assign rx_state        = mid_q;
   assign rx_input        = busy ? {32'd640, 320'd0, 32'h8000_0000, nonce_q, tail_q} : '0;
   assign golden_valid    = gv_q;
   assign golden_nonce    = gn_q;
   assign golden_overflow = ovf_q;
   assign unused_hash     = ^tx_hash;

endmodule

// File: tb/tb_sha256_nonce_sequencer.sv
// Bench for sha256_nonce_sequencer: a 64-clock stub transform returns hashes keyed on the
// sampled nonce; issues and hits are scoreboarded against queues filled at job start.
module tb_sha256_nonce_sequencer;

   localparam int unsigned MainLoop = 4;
   localparam int unsigned SW_LOOP [4] = '{1, 2, 8, 64};

   logic         clk = 1'b0;
   logic         reset, start, golden_ready;
   logic [255:0] midstate, tx_hash;
   logic [95:0]  data_tail;
   logic [31:0]  nonce_start, nonce_end, golden_nonce;
   logic         busy, done, feedback, golden_valid, golden_overflow;
   logic [5:0]   cnt;
   logic [255:0] rx_state;
   logic [511:0] rx_input;

   logic         start_sw;
   logic [3:0]   sw_done;
   int           sw_done_cyc [4];

   int checks = 0, failures = 0;
   int cyc = 0, start_cyc = 0, last_iss = 0, iss_idx = 0, hit_mode = 0;
   logic [31:0]  iss_q [$];
   logic [31:0]  hit_q [$];
   logic [95:0]  cur_tail;
   logic [255:0] cur_mid;

   typedef struct {
      logic [31:0] ns;
      logic [31:0] ne;
      int          mode;
      bit          ready;
      int          exp_cnt;
      int          exp_lat;
      bit          exp_ovf;
   } vec_t;
   vec_t vecs [5];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sha256_nonce_sequencer #(.LOOP(MainLoop), .ZERO_BITS(8)) u_dut (
      .clk(clk), .reset(reset), .start(start), .midstate(midstate), .data_tail(data_tail),
      .nonce_start(nonce_start), .nonce_end(nonce_end), .busy(busy), .done(done),
      .feedback(feedback), .cnt(cnt), .rx_state(rx_state), .rx_input(rx_input),
      .tx_hash(tx_hash), .golden_valid(golden_valid), .golden_ready(golden_ready),
      .golden_nonce(golden_nonce), .golden_overflow(golden_overflow)
   );

   genvar g;
   for (g = 0; g < 4; g++) begin : g_sw
      logic         unused_busy, unused_fb, unused_gv, unused_ovf;
      logic [5:0]   unused_cnt;
      logic [255:0] unused_state;
      logic [511:0] unused_input;
      logic [31:0]  unused_gn;
      sha256_nonce_sequencer #(.LOOP(SW_LOOP[g]), .ZERO_BITS(32)) u_sw (
         .clk(clk), .reset(reset), .start(start_sw), .midstate(midstate), .data_tail(data_tail),
         .nonce_start(32'd10), .nonce_end(32'd19), .busy(unused_busy), .done(sw_done[g]),
         .feedback(unused_fb), .cnt(unused_cnt), .rx_state(unused_state),
         .rx_input(unused_input), .tx_hash({256{1'b1}}), .golden_valid(unused_gv),
         .golden_ready(1'b1), .golden_nonce(unused_gn), .golden_overflow(unused_ovf)
      );
   end

   function automatic bit is_hit(input logic [31:0] n);
      case (hit_mode)
         1:       return (n % 5) == 2;
         2:       return (n == 32'd3) || (n == 32'd7);
         default: return 1'b0;
      endcase
   endfunction

   // Stub transform: hash for the block sampled at issue edge E appears after edge E+64.
   // Hits sit exactly on the 8-bit boundary; misses have the next bit set.
   bit [32:0] dl [64];
   bit [32:0] samp;
   always @(negedge clk) samp = {cnt == 6'd0, rx_input[127:96]};
   always @(posedge clk) begin
      if (dl[63][32] && is_hit(dl[63][31:0])) tx_hash <= {32'h00FF_FFFF, {7{32'hDEAD_BEEF}}};
      else                                    tx_hash <= {32'h0100_0000, {7{32'hDEAD_BEEF}}};
      for (int i = 63; i > 0; i--) dl[i] = dl[i-1];
      dl[0] = samp;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Issue, slot-counter and hit monitors.
   always @(negedge clk) begin
      if (!reset && busy) begin
         int unsigned e;
         e = (cyc - start_cyc) % MainLoop;
         check("cnt_fb", {57'd0, feedback, cnt}, {57'd0, e != 0, 6'(e)});
         if (cnt == 6'd0 && iss_q.size() > 0) begin
            logic [31:0]  n;
            logic [511:0] blk;
            n   = iss_q.pop_front();
            blk = {32'd640, 320'd0, 32'h8000_0000, n, cur_tail};
            check("issue_nonce", {32'd0, rx_input[127:96]}, {32'd0, n});
            check("issue_block", {63'd0, rx_input == blk}, 64'd1);
            if (iss_idx == 0) check("first_issue_cycle", 64'(cyc), 64'(start_cyc));
            else              check("issue_spacing", 64'(cyc - last_iss), 64'(MainLoop));
            last_iss = cyc;
            iss_idx++;
         end
      end
      if (!reset && golden_valid && golden_ready) begin
         if (hit_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL golden_unexpected: got nonce %0h expected no hit", golden_nonce);
         end else begin
            logic [31:0] n;
            n = hit_q.pop_front();
            check("golden_nonce", {32'd0, golden_nonce}, {32'd0, n});
         end
      end
   end

   always @(negedge clk)
      for (int i = 0; i < 4; i++) if (sw_done[i] && sw_done_cyc[i] < 0) sw_done_cyc[i] = cyc;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_job(input logic [31:0] ns, input logic [31:0] ne);
      for (int i = 0; i < 8; i++) midstate[i*32 +: 32] = $urandom;
      data_tail   = {$urandom, $urandom, $urandom};
      nonce_start = ns;
      nonce_end   = ne;
      cur_mid     = midstate;
      cur_tail    = data_tail;
      start_cyc   = cyc + 1;
      iss_idx     = 0;
      start       = 1'b1;
   endtask

   task automatic run_job(input vec_t v);
      bit seen;
      int nhits;
      hit_mode     = v.mode;
      golden_ready = v.ready;
      nhits        = 0;
      for (int i = 0; i < v.exp_cnt; i++) begin
         logic [31:0] n;
         n = v.ns + 32'(i);
         iss_q.push_back(n);
         if (is_hit(n)) begin
            if (v.ready || nhits == 0) hit_q.push_back(n);
            nhits++;
         end
      end
      load_job(v.ns, v.ne);
      seen = 1'b0;
      for (int k = 0; k < v.exp_lat + 60; k++) begin
         step();
         if (k == 0) start = 1'b0;
         if (k == 8) begin
            start       = 1'b1;
            nonce_start = 32'hABCD_0000;
            midstate    = ~cur_mid;
         end
         if (k == 9) start = 1'b0;
         if (k == 10) begin
            check("rx_state_lo", rx_state[63:0], cur_mid[63:0]);
            check("rx_state_hi", rx_state[255:192], cur_mid[255:192]);
            check("ovf_clear_on_start", {63'd0, golden_overflow}, 64'd0);
            check("busy_running", {63'd0, busy}, 64'd1);
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: got no done expected done at +%0d", v.exp_lat);
      end else begin
         check("done_latency", 64'(cyc - start_cyc), 64'(v.exp_lat));
         check("busy_with_done", {63'd0, busy}, 64'd0);
      end
      step();
      check("done_one_cycle", {62'd0, done, busy}, 64'd0);
      check("issues_left", 64'(iss_q.size()), 64'd0);
      if (v.ready) check("hits_left", 64'(hit_q.size()), 64'd0);
      check("overflow", {63'd0, golden_overflow}, {63'd0, v.exp_ovf});
      iss_q.delete();
   endtask

   initial begin
      vecs[0] = '{32'h5,         32'h5,         0, 1'b1, 1,    66,   1'b0};
      vecs[1] = '{32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b1, 4,    78,   1'b0};
      vecs[2] = '{32'd0,         32'd11,        1, 1'b1, 12,   110,  1'b0};
      vecs[3] = '{32'd0,         32'd9,         2, 1'b0, 10,   102,  1'b1};
      vecs[4] = '{32'd0,         32'd1023,      1, 1'b1, 1024, 4158, 1'b0};

      reset = 1'b1; start = 1'b0; start_sw = 1'b0; golden_ready = 1'b1;
      midstate = '0; data_tail = '0; nonce_start = '0; nonce_end = '0;
      for (int i = 0; i < 4; i++) sw_done_cyc[i] = -1;
      repeat (3) step();
      reset = 1'b0;
      check("reset_outputs", {51'd0, busy, done, feedback, cnt, golden_valid, golden_overflow,
            |rx_state, |rx_input, |golden_nonce}, 64'd0);

      // Abort a job mid-RUN with reset; stale hashes in the stub would be hits.
      hit_mode = 1;
      load_job(32'd0, 32'd99);
      step();
      start = 1'b0;
      repeat (30) step();
      reset = 1'b1;
      step();
      check("reset_mid_run", {51'd0, busy, done, feedback, cnt, golden_valid, golden_overflow,
            |rx_state, |rx_input, |golden_nonce}, 64'd0);
      step();
      reset = 1'b0;
      begin
         int quiet_bad;
         quiet_bad = 0;
         for (int k = 0; k < 200; k++) begin
            step();
            if (done || golden_valid || busy) quiet_bad++;
         end
         check("idle_quiet", 64'(quiet_bad), 64'd0);
      end

      for (int i = 0; i < 4; i++) run_job(vecs[i]);

      // Dropped hit: nonce 3 stays pending after done until the consumer takes it.
      check("pending_valid", {63'd0, golden_valid}, 64'd1);
      check("pending_nonce", {32'd0, golden_nonce}, 64'd3);
      golden_ready = 1'b1;
      step();
      step();
      check("after_pop_valid", {63'd0, golden_valid}, 64'd0);
      check("after_pop_queue", 64'(hit_q.size()), 64'd0);

      run_job(vecs[4]);

      // LOOP sweep: 10 nonces each, done at (10-1)*LOOP+66.
      start_sw = 1'b1;
      start_cyc = cyc + 1;
      begin
         int base;
         base = cyc + 1;
         step();
         start_sw = 1'b0;
         for (int k = 0; k < 800 && (sw_done_cyc[0] < 0 || sw_done_cyc[1] < 0 ||
              sw_done_cyc[2] < 0 || sw_done_cyc[3] < 0); k++) step();
         for (int i = 0; i < 4; i++) begin
            if (sw_done_cyc[i] < 0) begin
               checks++;
               failures++;
               $display("FAIL sweep_timeout: LOOP=%0d got no done", SW_LOOP[i]);
            end else begin
               check($sformatf("sweep_done_loop%0d", SW_LOOP[i]), 64'(sw_done_cyc[i] - base),
                     64'(9 * SW_LOOP[i] + 66));
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
